// File: rtl/acc_drain.sv
// rtl/acc_drain.sv - accumulator result capture, reserved-slot FIFO and AXI-Stream output
module acc_drain #(
  parameter int WidthY  = 16,
  parameter int Latency = 1,
  parameter int Depth   = 4,
  parameter int Beats   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              acc_en_o,
  input  logic              acc_valid_i,
  input  logic              acc_last_i,
  input  logic [WidthY-1:0] acc_y_i,
  output logic [WidthY-1:0] m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              m_axis_tlast_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam int BW = (Beats > 1) ? $clog2(Beats) : 1;

  logic [Latency-1:0] r_tag;
  logic [WidthY-1:0]  r_mem [Depth];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [BW-1:0]      r_beat;

  logic [31:0]        w_inflight;
  logic [31:0]        w_reserved;
  logic               w_en;
  logic               w_push;
  logic               w_pop;

  // Slots already claimed: buffered results plus results still travelling through the accumulator
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < Latency; i++) begin
      w_inflight = w_inflight + 32'(r_tag[i]);
    end
    w_reserved = 32'(r_count) + w_inflight;
  end

  // Only let a new term enter the accumulator when every in-flight result is guaranteed a slot
  assign w_en     = !rst_i && (w_reserved < 32'(Depth));
  assign acc_en_o = w_en;

  assign w_push = w_en && r_tag[Latency-1];
  assign w_pop  = m_axis_tvalid_o && m_axis_tready_i;

  assign m_axis_tvalid_o = (r_count != '0);
  assign m_axis_tdata_o  = r_mem[r_rd_ptr];
  assign m_axis_tlast_o  = m_axis_tvalid_o && (r_beat == BW'(Beats - 1));

  // Tag pipe follows each final term through the enable-gated accumulator latency
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_tag <= '0;
    end else if (w_en) begin
      r_tag[0] <= acc_valid_i & acc_last_i;
      for (int i = 1; i < Latency; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Circular result buffer; reservation above makes overflow impossible
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= acc_y_i;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Beat position inside the current output packet, advanced on every accepted result
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == BW'(Beats - 1)) ? '0 : r_beat + BW'(1);
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// tb/tb_acc_drain.sv - self-checking bench for acc_drain
module tb_acc_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: Latency 1, Depth 4, Beats 2
  logic        rst_a = 1'b1;
  logic        vld_a = 1'b0, lst_a = 1'b0, rdy_a = 1'b0;
  logic [15:0] x_a = '0;
  logic [15:0] acc_y_a;
  logic        en_a, tv_a, tl_a;
  logic [15:0] td_a;

  // instance B: Latency 3, Depth 8, Beats 8
  logic        rst_b = 1'b1;
  logic        vld_b = 1'b0, lst_b = 1'b0, rdy_b = 1'b0;
  logic [15:0] y_b = '0;
  logic        en_b, tv_b, tl_b;
  logic [15:0] td_b;

  acc_drain #(.WidthY(16), .Latency(1), .Depth(4), .Beats(2)) u_a (
    .clk_i(clk), .rst_i(rst_a), .acc_en_o(en_a),
    .acc_valid_i(vld_a), .acc_last_i(lst_a), .acc_y_i(acc_y_a),
    .m_axis_tdata_o(td_a), .m_axis_tvalid_o(tv_a),
    .m_axis_tready_i(rdy_a), .m_axis_tlast_o(tl_a)
  );

  acc_drain #(.WidthY(16), .Latency(3), .Depth(8), .Beats(8)) u_b (
    .clk_i(clk), .rst_i(rst_b), .acc_en_o(en_b),
    .acc_valid_i(vld_b), .acc_last_i(lst_b), .acc_y_i(y_b),
    .m_axis_tdata_o(td_b), .m_axis_tvalid_o(tv_b),
    .m_axis_tready_i(rdy_b), .m_axis_tlast_o(tl_b)
  );

  // Upstream accumulator stand-in for A: running sum, one enabled cycle of latency
  logic        en_a_q = 1'b0;
  logic [15:0] m_sum;
  always @(negedge clk) en_a_q <= en_a;
  always @(posedge clk) begin
    if (rst_a) begin
      m_sum   <= '0;
      acc_y_a <= '0;
    end else if (en_a_q && vld_a) begin
      acc_y_a <= m_sum + x_a;
      m_sum   <= lst_a ? 16'd0 : m_sum + x_a;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model for A: dot products completed but not yet delivered, in order
  logic [15:0] mq[$];
  logic [15:0] run;
  int          npop;
  logic        stall_a, hold_l;
  logic [15:0] hold_d;
  logic        s_tvalid, s_tlast;
  logic [15:0] s_tdata;

  task automatic clear_model();
    mq.delete();
    run     = '0;
    npop    = 0;
    stall_a = 1'b0;
  endtask

  task automatic cyc_a(input logic v, input logic l, input logic [15:0] x, input logic rdy,
                       output logic took);
    vld_a = v; lst_a = l; x_a = x; rdy_a = rdy;
    @(negedge clk);
    took     = 1'b0;
    s_tvalid = tv_a; s_tdata = td_a; s_tlast = tl_a;
    check("en_reserved", en_a, (mq.size() < 4));
    if (stall_a) begin
      check("no_retract", tv_a, 1);
      check("hold_data", td_a, hold_d);
      check("hold_last", tl_a, hold_l);
    end
    if (tv_a) begin
      check("tvalid_has_result", (mq.size() != 0), 1);
      if (rdy && mq.size() != 0) begin
        check("pop_data", td_a, mq[0]);
        check("pop_last", tl_a, (npop % 2) == 1);
        void'(mq.pop_front());
        npop++;
      end
    end
    stall_a = tv_a && !rdy;
    hold_d  = td_a;
    hold_l  = tl_a;
    if (en_a && v) begin
      took = 1'b1;
      run  = run + x;
      if (l) begin
        mq.push_back(run);
        run = '0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1; vld_a = 1'b0; lst_a = 1'b0; rdy_a = 1'b0;
    @(negedge clk);
    check("rst_en_low", en_a, 0);
    @(posedge clk); #1;
    rst_a = 1'b0;
    clear_model();
    @(negedge clk);
    check("post_rst_en", en_a, 1);
    check("post_rst_tvalid", tv_a, 0);
    check("post_rst_tlast", tl_a, 0);
    check("post_rst_tdata", td_a, 0);
    @(posedge clk); #1;
  endtask

  task automatic offer_a(input logic [15:0] x, input logic rdy);
    logic took;
    took = 1'b0;
    for (int b = 0; b < 20 && !took; b++) cyc_a(1'b1, 1'b1, x, rdy, took);
    check("offer_accepted", took, 1);
  endtask

  task automatic drain_a(input logic toggle);
    logic took;
    for (int b = 0; b < 60 && mq.size() != 0; b++) begin
      logic r;
      r = toggle ? logic'(b % 2) : 1'b1;
      cyc_a(1'b0, 1'b0, 16'd0, r, took);
    end
    check("drain_empty", mq.size(), 0);
  endtask

  typedef struct {
    logic        v;
    logic        l;
    logic [15:0] x;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        el;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic took;
    logic tog;
    int   k;

    // single result (5, -2, 7), then a stray last with valid low
    tbl[0]  = '{1'b1, 1'b0, 16'd5,      1'b1, 1'b0, 16'd0,  1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'hFFFE,   1'b1, 1'b0, 16'd0,  1'b0};
    tbl[2]  = '{1'b1, 1'b1, 16'd7,      1'b1, 1'b0, 16'd0,  1'b0};
    tbl[3]  = '{1'b0, 1'b0, 16'd0,      1'b1, 1'b0, 16'd0,  1'b0};
    tbl[4]  = '{1'b0, 1'b0, 16'd0,      1'b1, 1'b1, 16'd10, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 16'd0,      1'b1, 1'b0, 16'd0,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 16'd99,     1'b1, 1'b0, 16'd0,  1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'd99,     1'b1, 1'b0, 16'd0,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'd99,     1'b1, 1'b0, 16'd0,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 16'd0,      1'b1, 1'b0, 16'd0,  1'b0};
    tbl[10] = '{1'b0, 1'b0, 16'd0,      1'b1, 1'b0, 16'd0,  1'b0};

    clear_model();
    reset_a();
    for (int i = 0; i < 11; i++) begin
      cyc_a(tbl[i].v, tbl[i].l, tbl[i].x, tbl[i].rdy, took);
      check($sformatf("tbl%0d_tvalid", i), s_tvalid, tbl[i].ev);
      check($sformatf("tbl%0d_tlast", i), s_tlast, tbl[i].el);
      if (tbl[i].ev) check($sformatf("tbl%0d_tdata", i), s_tdata, tbl[i].ed);
    end

    // non-final terms never produce output
    for (int i = 0; i < 10; i++) begin
      cyc_a(1'b1, 1'b0, 16'd3, 1'b1, took);
      check("nonfinal_tvalid", s_tvalid, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b0, 1'b0, 16'd0, 1'b1, took);
      check("nonfinal_idle_tvalid", s_tvalid, 0);
    end

    // backpressure: four slots fill, fifth result must wait
    reset_a();
    for (int i = 1; i <= 4; i++) offer_a(16'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc_a(1'b1, 1'b1, 16'd5, 1'b0, took);
      check("bp_fifth_blocked", took, 0);
    end
    offer_a(16'd5, 1'b1);
    drain_a(1'b0);
    check("bp_total_pops", npop, 5);

    // packet wrap with tready toggling every cycle
    reset_a();
    k = 1; tog = 1'b0;
    for (int b = 0; b < 60 && k <= 6; b++) begin
      cyc_a(1'b1, 1'b1, 16'(k), tog, took);
      tog = !tog;
      if (took) k++;
    end
    check("wrap_all_offered", k, 7);
    drain_a(1'b1);
    check("wrap_total_pops", npop, 6);

    // reset with three buffered results and one in flight
    reset_a();
    for (int i = 1; i <= 4; i++) offer_a(16'(i), 1'b0);
    reset_a();
    offer_a(16'd7, 1'b1);
    offer_a(16'd8, 1'b1);
    drain_a(1'b0);
    check("rst_mid_pops", npop, 2);

    // randomized traffic against the queue model
    reset_a();
    for (int i = 0; i < 400; i++) begin
      cyc_a(logic'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            16'($urandom), ($urandom_range(0, 2) != 0), took);
    end
    drain_a(1'b0);

    // deep latency on B
    @(negedge clk);
    check("b_rst_en", en_b, 0);
    check("b_rst_tvalid", tv_b, 0);
    check("b_rst_tdata", td_b, 0);
    @(posedge clk); #1;
    rst_b = 1'b0; rdy_b = 1'b1; y_b = 16'h8000;
    @(negedge clk);
    check("b_post_rst_en", en_b, 1);
    @(posedge clk); #1;
    vld_b = 1'b1; lst_b = 1'b1;
    @(negedge clk);
    check("b_deep_en_t", en_b, 1);
    @(posedge clk); #1;
    vld_b = 1'b0; lst_b = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("b_deep_tvalid_t+%0d", c), tv_b, (c == 4));
      if (c == 4) begin
        check("b_deep_tdata", td_b, 16'h8000);
        check("b_deep_tlast", tl_b, 0);
      end
      @(posedge clk); #1;
    end

    // B: seven results parked, eighth term stalls the pipe for two cycles
    rdy_b = 1'b0; y_b = 16'h0001;
    for (int i = 0; i < 7; i++) begin
      vld_b = 1'b1; lst_b = 1'b1;
      @(negedge clk);
      check("b_fill_en", en_b, 1);
      @(posedge clk); #1;
    end
    vld_b = 1'b0; lst_b = 1'b0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    vld_b = 1'b1; lst_b = 1'b1; y_b = 16'h8000;
    @(negedge clk);
    check("b_stall_en_t", en_b, 1);
    @(posedge clk); #1;
    vld_b = 1'b0; lst_b = 1'b0;
    @(negedge clk);
    check("b_stall_en_t+1", en_b, 0);
    @(posedge clk); #1;
    rdy_b = 1'b1;
    // fill results pop at t+2..t+8; the stalled result lands behind them and heads at t+9
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      if (c == 2) check("b_stall_en_t+2", en_b, 0);
      if (c == 3) check("b_stall_en_t+3", en_b, 1);
      check($sformatf("b_stall_tvalid_t+%0d", c), tv_b, (c <= 9));
      if (c <= 9) begin
        check($sformatf("b_stall_tdata_t+%0d", c), td_b, (c == 9) ? 16'h8000 : 16'h0001);
        check($sformatf("b_stall_tlast_t+%0d", c), tl_b, (c == 8));
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
